wallace_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 32x32 Wallace multiplier (Wallace_Multiplier_32Bit) among NUM_REQ requesters. It registers the granted operands, drives the multiplier, and registers the 64-bit product. It returns the product on a valid/ready response channel tagged with the requester index. A completed-operation counter is kept for performance monitoring.

---
 rtl/wallace_mul_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wallace_mul_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 32x32 Wallace multiplier among NUM_REQ requesters.
// Operands and product are registered; results return on a valid/ready channel tagged with the requester index.
module wallace_mul_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [2*DATA_WIDTH-1:0]       rsp_data,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          busy,
  output logic [31:0]                   op_count
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned PP_ROWS    = 32;
  localparam int unsigned CSA_LAYERS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [DATA_WIDTH-1:0]   b_reg;
  logic [ID_WIDTH-1:0]     id_reg;

  logic                    found;
  logic [ID_WIDTH-1:0]     winner;
  logic [ID_WIDTH-1:0]     next_ptr;
  logic [NUM_REQ-1:0]      grant;
  logic [PROD_WIDTH-1:0]   product;

  // Wallace tree: 32 partial-product rows reduced by layers of 3:2 compressors
  // (32->22->15->10->7->5->4->3->2), then one carry-propagate add.
  function automatic logic [63:0] wallace_multiplier_32bit(input logic [31:0] a,
                                                           input logic [31:0] b);
    logic [63:0] rows      [PP_ROWS];
    logic [63:0] next_rows [PP_ROWS];
    logic [63:0] sum;
    logic [63:0] carry;
    int unsigned n;
    int unsigned m;
    for (int unsigned i = 0; i < PP_ROWS; i++) begin
      rows[5'(i)] = b[5'(i)] ? (64'(a) << i) : 64'd0;
    end
    n = PP_ROWS;
    for (int unsigned layer = 0; layer < CSA_LAYERS; layer++) begin
      m = 0;
      for (int unsigned r = 0; r < PP_ROWS; r++) begin
        next_rows[5'(r)] = 64'd0;
      end
      for (int unsigned g = 0; g < PP_ROWS / 3; g++) begin
        if (3 * g + 2 < n) begin
          sum   = rows[5'(3*g)] ^ rows[5'(3*g+1)] ^ rows[5'(3*g+2)];
          carry = ((rows[5'(3*g)]   & rows[5'(3*g+1)]) |
                   (rows[5'(3*g)]   & rows[5'(3*g+2)]) |
                   (rows[5'(3*g+1)] & rows[5'(3*g+2)])) << 1;
          next_rows[5'(m)]   = sum;
          next_rows[5'(m+1)] = carry;
          m = m + 2;
        end
      end
      // Rows left over after grouping pass straight to the next layer.
      for (int unsigned r = 0; r < PP_ROWS; r++) begin
        if (r >= (n / 3) * 3 && r < n) begin
          next_rows[5'(m)] = rows[5'(r)];
          m = m + 1;
        end
      end
      rows = next_rows;
      n    = m;
    end
    return rows[0] + rows[1];
  endfunction

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_valid[ID_WIDTH'(idx)]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) begin
      grant[winner] = 1'b1;
    end
  end

  assign next_ptr  = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + ID_WIDTH'(1);
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign product   = wallace_multiplier_32bit(a_reg, b_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      id_reg    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_reg  <= req_a[winner*DATA_WIDTH +: DATA_WIDTH];
            b_reg  <= req_b[winner*DATA_WIDTH +: DATA_WIDTH];
            id_reg <= winner;
            rr_ptr <= next_ptr;
            busy   <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          rsp_data  <= product;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 32'd1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Directed bench for wallace_mul_arbiter: expected products/tags queued at grant, compared at response.
module tb_wallace_mul_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a;
  logic [N*DW-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*DW-1:0]   rsp_data;
  logic [IW-1:0]     rsp_id;
  logic              busy;
  logic [31:0]       op_count;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [2*DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  wallace_mul_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic expect_grant(input int id, input string tag);
    logic [3:0] oh;
    exp_t       e;
    #1;
    oh     = '0;
    oh[id] = 1'b1;
    chk(tag, 64'(req_ready), 64'(oh));
    e.id   = 2'(id);
    e.data = 64'(req_a[id*32 +: 32]) * 64'(req_b[id*32 +: 32]);
    sb.push_back(e);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    if (sb.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL %s_sb: observed empty scoreboard expected pending entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, rsp_data, e.data);
      chk({tag, "_id"}, 64'(rsp_id), 64'(e.id));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_op_count",  64'(op_count),  64'd0);
    chk("rst_rsp_data",  rsp_data,       64'd0);
    chk("rst_rsp_id",    64'(rsp_id),    64'd0);
    rst_n     = 1'b1;
    req_valid = '0;
    tick();

    // Single requester 2: 7*6.
    set_req(2, 32'd7, 32'd6);
    req_valid = 4'b0100;
    expect_grant(2, "t1_grant");
    tick();
    req_valid = '0;
    chk("t1_busy_mul", 64'(busy),      64'd1);
    chk("t1_no_rsp",   64'(rsp_valid), 64'd0);
    chk("t1_ready_mul", 64'(req_ready), 64'd0);
    tick();
    check_rsp("t1_rsp");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_rsp_done", 64'(rsp_valid), 64'd0);
    chk("t1_op_count", 64'(op_count),  64'd1);
    chk("t1_idle",     64'(busy),      64'd0);

    // All requesters continuously valid: rotation 0,1,2,3,0 at 3 cycles each.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_grant(i % 4, "t2_grant");
      tick();
      chk("t2_mul_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
      check_rsp("t2_rsp");
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("t2_op_count", 64'(op_count), 64'd5);

    // Backpressure: requester 1 result held 5 cycles while requester 3 waits.
    set_req(1, 32'h1111_1111, 32'h2222_2222);
    set_req(3, 32'd9, 32'd9);
    req_valid = 4'b1010;
    expect_grant(1, "t3_grant1");
    tick();
    req_valid = 4'b1000;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t3_hold_data",  rsp_data,       64'h0246_8ACF_0ECA_8642);
      chk("t3_hold_id",    64'(rsp_id),    64'd1);
      chk("t3_hold_ready", 64'(req_ready), 64'd0);
      tick();
    end
    check_rsp("t3_rsp1");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    expect_grant(3, "t3_grant3");
    tick();
    req_valid = '0;
    tick();
    check_rsp("t3_rsp3");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t3_op_count", 64'(op_count), 64'd7);

    // Zero operand, then operands change after acceptance.
    set_req(0, 32'd0, 32'hDEAD_BEEF);
    req_valid = 4'b0001;
    expect_grant(0, "t4_grant0");
    tick();
    set_req(0, 32'd3, 32'd5);
    tick();
    check_rsp("t4_rsp_zero");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    expect_grant(0, "t4_grant0b");
    tick();
    req_valid = '0;
    tick();
    check_rsp("t4_rsp_15");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset during HOLD discards result and restarts the pointer.
    set_req(0, 32'd1234, 32'd5678);
    req_valid = 4'b0001;
    expect_grant(0, "t5_grant");
    tick();
    req_valid = '0;
    tick();
    check_rsp("t5_held");
    rst_n = 1'b0;
    tick();
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_busy",      64'(busy),      64'd0);
    chk("t5_op_count",  64'(op_count),  64'd0);
    rst_n = 1'b1;
    set_req(0, 32'd100, 32'd200);
    set_req(1, 32'd3, 32'd3);
    req_valid = 4'b0011;
    expect_grant(0, "t5_grant_after_rst");
    tick();
    req_valid = '0;
    tick();
    check_rsp("t5_rsp");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t5_op_count_1", 64'(op_count), 64'd1);

    // op_count wrap from all-ones.
    set_req(2, 32'hFFFF_0000, 32'h0001_0000);
    req_valid = 4'b0100;
    expect_grant(2, "t6_grant");
    tick();
    req_valid = '0;
    tick();
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    check_rsp("t6_rsp");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t6_op_count_wrap", 64'(op_count),  64'd0);
    chk("t6_rsp_done",      64'(rsp_valid), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
